// File: rtl/shift_pkg.sv
// Shared constants for the sequential shifter: operand width, op encodings and FSM states.
package shift_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    typedef logic [1:0] op_t;

    localparam op_t OP_LLS = 2'b00;
    localparam op_t OP_LRS = 2'b01;
    localparam op_t OP_ARS = 2'b10;
    localparam op_t OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_seq_if.sv
// Start/done transaction bundle between a requester (master) and the shifter (slave).
interface shift_seq_if;
    import shift_pkg::*;

    logic             start;
    op_t              op;
    logic [WIDTH-1:0] data_in;
    logic [CNT_W-1:0] amount;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, data_in, amount,
        input  ready, done, result
    );

    modport slave (
        input  start, op, data_in, amount,
        output ready, done, result
    );

endinterface

// File: rtl/shift_seq_step.sv
// One-bit shift of a vector selected by op. Sign fill for OP_ARS only when
// SHIFT_SEQ_ARITH_EN is defined; otherwise OP_ARS is a plain logical right shift.
module shift_seq_step
    import shift_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  op_t          op,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            OP_LLS: dout = {din[W-2:0], 1'b0};
            OP_LRS: dout = {1'b0, din[W-1:1]};
`ifdef SHIFT_SEQ_ARITH_EN
            OP_ARS: dout = {din[W-1], din[W-1:1]};
`else
            OP_ARS: dout = {1'b0, din[W-1:1]};
`endif
            OP_ROR: dout = {din[0], din[W-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: accepts an operand, count and op, then shifts one bit per clock.
// Optional feature macro: SHIFT_SEQ_ARITH_EN (sign-filling arithmetic right shift).
module shift_seq
    import shift_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    shift_seq_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] step_out;

    shift_seq_step #(.W(WIDTH)) u_step (
        .op   (op_q),
        .din  (result_q),
        .dout (step_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    result_d = bus.data_in;
                    cnt_d    = bus.amount;
                    op_d     = bus.op;
                    state_d  = (bus.amount == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                result_d = step_out;
                cnt_d    = cnt_q - 1'b1;
                // The last step is applied in the same cycle the count runs out.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_LLS;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    assign bus.ready  = (state_q == ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;

endmodule
